// File: rtl/mem_stream_reader_pkg.sv
// Shared types and helpers for the memory stream reader and its FIFO.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package mem_stream_reader_pkg;

  // Burst controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Output buffer depth; the read credit scheme is sized around it
  localparam int unsigned FIFO_ENTRIES = 3;

endpackage

// File: rtl/mem_stream_reader_if.sv
// Memory read port plus output stream of the burst reader.
interface mem_stream_reader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
) ();

  localparam int unsigned AW = `CLOG2(DEPTH);

  logic             mem_rden;
  logic [AW-1:0]    mem_rdaddress;
  logic [WIDTH-1:0] mem_q;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  // Reader side: drives the memory request and the stream
  modport master (
    output mem_rden, mem_rdaddress,
    input  mem_q,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  // Environment side: memory and stream consumer
  modport slave (
    input  mem_rden, mem_rdaddress,
    output mem_q,
    input  out_data, out_valid, out_last,
    output out_ready
  );

endinterface

// File: rtl/mem_stream_reader_rd_fifo.sv
// Small synchronous FIFO buffering words returned by the memory.
module mem_rd_fifo #(
  parameter  int unsigned W  = 8,
  parameter  int unsigned D  = 3,
  localparam int unsigned CW = `CLOG2(D + 1),
  localparam int unsigned PW = `CLOG2(D)
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  entries [D];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap by explicit compare so D need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count_q == CW'(D));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = entries[rd_ptr];
  assign count    = count_q;

  // Entry storage
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < D; i++) entries[i] <= '0;
    end else if (do_push) begin
      entries[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop keeps the count
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The upstream credit scheme must never push into a full buffer
  assert property (@(posedge clock) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/mem_stream_reader.sv
// Burst reader: fetches length words from base_addr and streams them out.
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned DEPTH  = 64,
  parameter  int unsigned FIFO_D = FIFO_ENTRIES,
  localparam int unsigned AW     = `CLOG2(DEPTH),
  localparam int unsigned LW     = `CLOG2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] length,
  output logic          busy,
  output logic          done,
  mem_stream_reader_if.master bus
);

  localparam int unsigned CW  = `CLOG2(FIFO_D + 1);
  localparam int unsigned CRW = CW + 1;

  state_t        state_q, state_d;
  logic          rden_q, rden_d;
  logic          pend_q;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW-1:0] next_addr_q, next_addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] issued_q, issued_d;
  logic [LW-1:0] pushed_q, pushed_d;
  logic [LW-1:0] beats_q, beats_d;
  logic          busy_q, done_q;

  logic           push;
  logic           pop;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  count_next;
  logic [CRW-1:0] credit_used;
  logic [WIDTH:0] push_word;
  logic [WIDTH:0] head_word;

  logic          cur_go;
  logic [AW-1:0] cur_addr;
  logic [LW-1:0] cur_len;
  logic [LW-1:0] cur_issued;

  // Next sequential address, wrapping at the top of memory
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  // A read issued last cycle returns data this cycle; tag the burst's final word
  assign push        = pend_q;
  assign push_word   = {(pushed_q == len_q - LW'(1)), bus.mem_q};
  assign pop         = !fifo_empty && bus.out_ready;
  assign count_next  = fifo_count + CW'(push) - CW'(pop);
  assign credit_used = CRW'(count_next) + CRW'(rden_q);

  mem_rd_fifo #(
    .W (WIDTH + 1),
    .D (FIFO_D)
  ) u_fifo (
    .clock     (clock),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (head_word),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next state, issue decision for the coming cycle, counter updates
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    next_addr_d = next_addr_q;
    raddr_d     = raddr_q;
    rden_d      = 1'b0;
    pushed_d    = push ? pushed_q + LW'(1) : pushed_q;
    beats_d     = pop ? beats_q + LW'(1) : beats_q;
    cur_go      = 1'b0;
    cur_addr    = next_addr_q;
    cur_len     = len_q;
    cur_issued  = issued_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d       = length;
          issued_d    = '0;
          pushed_d    = '0;
          beats_d     = '0;
          next_addr_d = base_addr;
          cur_go      = (length != '0);
          cur_addr    = base_addr;
          cur_len     = length;
          cur_issued  = '0;
          state_d     = (length == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        cur_go = 1'b1;
        if (issued_q == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && (beats_q == len_q - LW'(1))) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Issue only if next cycle's buffer plus the read in flight leaves room
    if (cur_go && (cur_issued < cur_len) && (credit_used < CRW'(FIFO_D))) begin
      rden_d      = 1'b1;
      raddr_d     = cur_addr;
      next_addr_d = addr_inc(cur_addr);
      issued_d    = cur_issued + LW'(1);
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rden_q      <= 1'b0;
      pend_q      <= 1'b0;
      raddr_q     <= '0;
      next_addr_q <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      pushed_q    <= '0;
      beats_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rden_q      <= rden_d;
      pend_q      <= rden_q;
      raddr_q     <= raddr_d;
      next_addr_q <= next_addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      pushed_q    <= pushed_d;
      beats_q     <= beats_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == FIN);
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign bus.mem_rden      = rden_q;
  assign bus.mem_rdaddress = raddr_q;
  assign bus.out_valid     = !fifo_empty;
  assign bus.out_data      = head_word[WIDTH-1:0];
  assign bus.out_last      = !fifo_empty && head_word[WIDTH];

endmodule
